// File: rtl/mmio_bridge.sv
// Data-memory port decoder for the mips core: data RAM window plus an I/O page with timer, LED and TX FIFO.
// Optional timer compare interrupt enabled by defining MMIO_TIMER_CMP_EN.
module mmio_bridge #(
    parameter int Dbits      = 32,
    parameter int DMEM_AW    = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int LEDW       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_wr,
    input  logic [31:0]        mem_addr,
    input  logic [Dbits-1:0]   mem_writedata,
    output logic [Dbits-1:0]   mem_readdata,
    output logic               cpu_stall,
    output logic               dmem_wr,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [Dbits-1:0]   dmem_wdata,
    input  logic [Dbits-1:0]   dmem_rdata,
    output logic [LEDW-1:0]    led,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OFF_TIMER  = 3'd0;
    localparam logic [2:0] OFF_LED    = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_TCMP   = 3'd4;

    logic             is_dmem, is_io, sel_tx, io_wr;
    logic [2:0]       io_off;
    logic             full, empty, push, pop, irq_int;
    logic [Dbits-1:0] io_rdata;

    logic [Dbits-1:0] timer_q, timer_d;
    logic [LEDW-1:0]  led_q, led_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Only the decoded fields of the byte address are used; the rest is deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    assign is_dmem = (mem_addr[31:16] == 16'h1001);
    assign is_io   = (mem_addr[31:16] == 16'h4000);
    assign io_off  = mem_addr[4:2];
    assign sel_tx  = is_io && (io_off == OFF_TXDATA);

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cpu_stall = mem_wr & sel_tx & full;
    assign io_wr     = mem_wr & is_io & ~cpu_stall;
    assign push      = mem_wr & sel_tx & ~full;
    assign pop       = tx_valid & tx_ready;

    assign dmem_wr    = mem_wr & is_dmem & ~cpu_stall;
    assign dmem_addr  = mem_addr[DMEM_AW+1:2];
    assign dmem_wdata = mem_writedata;

    assign led      = led_q;
    assign tx_valid = ~empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    always_comb begin
        timer_d  = timer_q + Dbits'(1);
        led_d    = led_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (io_wr && io_off == OFF_TIMER) timer_d = '0;
        if (io_wr && io_off == OFF_LED) led_d = mem_writedata[LEDW-1:0];
        if (push) begin
            fifo_d[wr_ptr_q] = mem_writedata[7:0];
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q  <= '0;
            led_q    <= '0;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            timer_q  <= timer_d;
            led_q    <= led_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef MMIO_TIMER_CMP_EN
    logic [Dbits-1:0] tcmp_q, tcmp_d;
    logic             irq_q, irq_d;
    logic             tcmp_wr;

    assign tcmp_wr = io_wr && (io_off == OFF_TCMP);

    // A TCMP write clears the flag, but a compare hit in that same cycle still sets it.
    always_comb begin
        tcmp_d = tcmp_wr ? mem_writedata : tcmp_q;
        irq_d  = (timer_q == tcmp_q) | (irq_q & ~tcmp_wr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcmp_q <= '1;
            irq_q  <= 1'b0;
        end else begin
            tcmp_q <= tcmp_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_int = irq_q;
`else
    assign irq_int = 1'b0;
`endif

    assign irq = irq_int;

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_TIMER: io_rdata = timer_q;
            OFF_LED:   io_rdata[LEDW-1:0] = led_q;
            OFF_STATUS: begin
                io_rdata[0]    = full;
                io_rdata[1]    = empty;
                io_rdata[2]    = tx_valid & ~tx_ready;
                io_rdata[3]    = irq_int;
                io_rdata[15:8] = 8'(count_q);
            end
`ifdef MMIO_TIMER_CMP_EN
            OFF_TCMP:  io_rdata = tcmp_q;
`endif
            default:   io_rdata = '0;
        endcase
    end

    always_comb begin
        mem_readdata = '0;
        if (is_dmem)    mem_readdata = dmem_rdata;
        else if (is_io) mem_readdata = io_rdata;
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge: decode, timer, LED, TX FIFO with stall, async reset, timer compare.
module tb_mmio_bridge;
    localparam logic [31:0] A_DMEM8  = 32'h1001_0008;
    localparam logic [31:0] A_UNMAP  = 32'h2000_0000;
    localparam logic [31:0] A_TIMER  = 32'h4000_0000;
    localparam logic [31:0] A_LED    = 32'h4000_0004;
    localparam logic [31:0] A_TXDATA = 32'h4000_0008;
    localparam logic [31:0] A_STATUS = 32'h4000_000C;
    localparam logic [31:0] A_TCMP   = 32'h4000_0010;
    localparam logic [31:0] A_OFF14  = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_writedata = '0;
    logic [31:0] mem_readdata;
    logic        cpu_stall;
    logic        dmem_wr;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;

    logic [31:0] ram [1024];
    int n_pass = 0;
    int n_total = 0;

    mmio_bridge dut (
        .clk(clk), .reset(reset), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .cpu_stall(cpu_stall),
        .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_wr) ram[dmem_addr] <= dmem_wdata;
    assign dmem_rdata = ram[dmem_addr];

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_writedata = d; mem_wr = 1'b1;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        mem_wr = 1'b0; mem_addr = a;
        #1;
        d = mem_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (2) @(negedge clk);
        n_total++; if ({led, tx_valid, tx_data, cpu_stall, irq} !== 27'd0)
            $display("FAIL reset_outputs: got %h required 0", {led, tx_valid, tx_data, cpu_stall, irq});
        else n_pass++;
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0002) $display("FAIL reset_status: got %h required 00000002", rd);
        else n_pass++;
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL reset_timer: got %h required 0", rd);
        else n_pass++;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_dmem();
        logic [31:0] rd;
        @(negedge clk);
        mem_addr = A_DMEM8; mem_writedata = 32'hDEAD_BEEF; mem_wr = 1'b1;
        #1;
        n_total++; if ({dmem_wr, dmem_addr, dmem_wdata} !== {1'b1, 10'd2, 32'hDEAD_BEEF})
            $display("FAIL dmem_store: got wr=%b addr=%0d wdata=%h required wr=1 addr=2 wdata=deadbeef",
                     dmem_wr, dmem_addr, dmem_wdata);
        else n_pass++;
        @(negedge clk);
        mem_wr = 1'b0;
        #1;
        n_total++; if (dmem_wr !== 1'b0) $display("FAIL dmem_wr_one_cycle: got %b required 0", dmem_wr);
        else n_pass++;
        load(A_DMEM8, rd);
        n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL dmem_load: got %h required deadbeef", rd);
        else n_pass++;
        @(negedge clk);
        mem_addr = A_UNMAP; mem_writedata = 32'h1234_5678; mem_wr = 1'b1;
        #1;
        n_total++; if (dmem_wr !== 1'b0) $display("FAIL unmapped_no_wr: got %b required 0", dmem_wr);
        else n_pass++;
        @(negedge clk);
        load(A_UNMAP, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL unmapped_read: got %h required 0", rd);
        else n_pass++;
        load(32'h1001_0000, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL unmapped_no_alias: got %h required 0", rd);
        else n_pass++;
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (100) @(negedge clk);
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'd100) $display("FAIL timer_100: got %0d required 100", rd);
        else n_pass++;
        store(A_TIMER, 32'h5555_5555);
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL timer_clear: got %0d required 0", rd);
        else n_pass++;
        @(negedge clk);
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'd1) $display("FAIL timer_after_clear: got %0d required 1", rd);
        else n_pass++;
        @(negedge clk);
        force dut.timer_q = 32'hFFFF_FFFE;
        #2;
        release dut.timer_q;
        @(negedge clk);
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL timer_max: got %h required ffffffff", rd);
        else n_pass++;
        @(negedge clk);
        load(A_TIMER, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL timer_wrap: got %h required 0", rd);
        else n_pass++;
    endtask

    task automatic test_led_map();
        logic [31:0] rd;
        store(A_LED, 32'hABCD_1234);
        n_total++; if (led !== 16'h1234) $display("FAIL led_out: got %h required 1234", led);
        else n_pass++;
        load(A_LED, rd);
        n_total++; if (rd !== 32'h0000_1234) $display("FAIL led_read: got %h required 00001234", rd);
        else n_pass++;
        load(A_TXDATA, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL txdata_read: got %h required 0", rd);
        else n_pass++;
        load(A_OFF14, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL io_hole_read: got %h required 0", rd);
        else n_pass++;
        store(A_STATUS, 32'hFFFF_FFFF);
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0002) $display("FAIL status_write_ignored: got %h required 00000002", rd);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [31:0] rd;
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) store(A_TXDATA, 32'hFFFF_FF00 | i);
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0805) $display("FAIL fifo_full_status: got %h required 00000805", rd);
        else n_pass++;
        @(negedge clk);
        mem_addr = A_TXDATA; mem_writedata = 32'h09; mem_wr = 1'b1;
        #1;
        n_total++; if (cpu_stall !== 1'b1) $display("FAIL stall_rise: got %b required 1", cpu_stall);
        else n_pass++;
        @(negedge clk);
        n_total++; if ({cpu_stall, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h01})
            $display("FAIL stall_held: got stall=%b valid=%b data=%h required 1 1 01", cpu_stall, tx_valid, tx_data);
        else n_pass++;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        n_total++; if ({cpu_stall, tx_data} !== {1'b0, 8'h02})
            $display("FAIL stall_drop: got stall=%b data=%h required 0 02", cpu_stall, tx_data);
        else n_pass++;
        @(negedge clk);
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0805) $display("FAIL held_push_status: got %h required 00000805", rd);
        else n_pass++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_total++; if ({tx_valid, tx_data} !== {1'b1, 8'(i + 2)})
                $display("FAIL drain_order[%0d]: got valid=%b data=%h required 1 %h", i, tx_valid, tx_data, 8'(i + 2));
            else n_pass++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        load(A_STATUS, rd);
        n_total++; if ({rd, tx_valid} !== {32'h0000_0002, 1'b0})
            $display("FAIL drained_empty: got status=%h valid=%b required 00000002 0", rd, tx_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        tx_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_total++; if ({tx_valid, tx_data, cpu_stall} !== {1'b1, 8'(8'h10 + k - 1), 1'b0})
                    $display("FAIL stream[%0d]: got valid=%b data=%h stall=%b required 1 %h 0",
                             k, tx_valid, tx_data, cpu_stall, 8'(8'h10 + k - 1));
                else n_pass++;
            end
            mem_addr = A_TXDATA; mem_writedata = 32'h10 + k; mem_wr = 1'b1;
        end
        @(negedge clk);
        n_total++; if (tx_data !== 8'h23) $display("FAIL stream_last: got %h required 23", tx_data);
        else n_pass++;
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0100) $display("FAIL stream_count1: got %h required 00000100", rd);
        else n_pass++;
        @(negedge clk);
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0002) $display("FAIL stream_empty: got %h required 00000002", rd);
        else n_pass++;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        store(A_LED, 32'h5A5A);
        for (int i = 0; i < 5; i++) store(A_TXDATA, 32'hA0 + i);
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0504) $display("FAIL pre_reset_status: got %h required 00000504", rd);
        else n_pass++;
        @(negedge clk);
        mem_addr = A_TXDATA; mem_writedata = 32'h77; mem_wr = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if ({led, tx_valid, tx_data, cpu_stall, irq} !== 27'd0)
            $display("FAIL async_reset_outputs: got %h required 0", {led, tx_valid, tx_data, cpu_stall, irq});
        else n_pass++;
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0002) $display("FAIL async_reset_status: got %h required 00000002", rd);
        else n_pass++;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        load(A_STATUS, rd);
        n_total++; if ({rd, led, tx_valid} !== {32'h0000_0002, 16'h0, 1'b0})
            $display("FAIL after_release: got status=%h led=%h valid=%b required 00000002 0000 0", rd, led, tx_valid);
        else n_pass++;
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        early;
`ifdef MMIO_TIMER_CMP_EN
        load(A_TCMP, rd);
        n_total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL tcmp_reset: got %h required ffffffff", rd);
        else n_pass++;
        repeat (60) @(negedge clk);
        store(A_TCMP, 32'd50);
        n_total++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b required 0", irq);
        else n_pass++;
        store(A_TIMER, 32'd0);
        early = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            early = early | irq;
        end
        n_total++; if (early !== 1'b0) $display("FAIL irq_early: got %b required 0", early);
        else n_pass++;
        @(negedge clk);
        n_total++; if (irq !== 1'b1) $display("FAIL irq_rise_51: got %b required 1", irq);
        else n_pass++;
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_000A) $display("FAIL status_irq: got %h required 0000000a", rd);
        else n_pass++;
        store(A_TCMP, 32'd1000);
        n_total++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b required 0", irq);
        else n_pass++;
        load(A_TCMP, rd);
        n_total++; if (rd !== 32'd1000) $display("FAIL tcmp_read: got %0d required 1000", rd);
        else n_pass++;
`else
        store(A_TCMP, 32'd50);
        load(A_TCMP, rd);
        n_total++; if (rd !== 32'd0) $display("FAIL tcmp_absent_read: got %h required 0", rd);
        else n_pass++;
        store(A_TIMER, 32'd0);
        early = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            early = early | irq;
        end
        n_total++; if (early !== 1'b0) $display("FAIL irq_tied_low: got %b required 0", early);
        else n_pass++;
        load(A_STATUS, rd);
        n_total++; if (rd !== 32'h0000_0002) $display("FAIL status_no_irq: got %h required 00000002", rd);
        else n_pass++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        test_reset();
        test_dmem();
        test_timer();
        test_led_map();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
